nx_ia_mem_arb: RTL

Single-port memory arbiter placed between a table's hardware datapath port and its indirect-access software controller. It multiplexes both requesters onto one SRAM/register-file port and returns the `grant` handshake the controller expects. It honours the controller's `yield` urgency flag and tags in-flight reads so read data is steered back to the requester that issued it. The hardware port has default priority; software is guaranteed forward progress.

---
 rtl/nx_ia_mem_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/nx_ia_mem_arb.sv
// nx_ia_mem_arb
// Single-port memory arbiter between a table's hardware datapath port (hw_*) and
// its indirect-access software controller (sw_*). Grants are combinational
// (zero latency). In-flight reads are tagged with their owner so that read data
// goes back to the requester that issued the read.
//
// Optional feature macro: NX_IA_MEM_ARB_STARVE_EN
//   defined   - anti-starvation counter forces a software grant after
//               2**N_STARVE_BITS-1 consecutive lost contested cycles
//   undefined - software wins only when hw is idle or sw_yield is set
//
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   hw_cs/hw_we/hw_add/hw_wdat            datapath request
//   hw_gnt                                datapath accepted this cycle
//   hw_rdat/hw_rvld                       datapath read return
//   sw_cs/sw_ce/sw_we/sw_add/sw_wdat      controller request (ce = compare)
//   sw_yield                              controller urgency
//   sw_grant                              controller accepted this cycle
//   sw_rdat                               controller read data (held)
//   mem_cs/mem_ce/mem_we/mem_add/mem_wdat memory port
//   mem_rdat                              memory read data
module nx_ia_mem_arb #(
    parameter int unsigned N_DATA_BITS   = 32,
    parameter int unsigned N_ENTRIES     = 1024,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned N_STARVE_BITS = 4,
    localparam int unsigned AW           = $clog2(N_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hw_cs,
    input  logic                   hw_we,
    input  logic [AW-1:0]          hw_add,
    input  logic [N_DATA_BITS-1:0] hw_wdat,
    output logic                   hw_gnt,
    output logic [N_DATA_BITS-1:0] hw_rdat,
    output logic                   hw_rvld,
    input  logic                   sw_cs,
    input  logic                   sw_ce,
    input  logic                   sw_we,
    input  logic [AW-1:0]          sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    input  logic                   sw_yield,
    output logic                   sw_grant,
    output logic [N_DATA_BITS-1:0] sw_rdat,
    output logic                   mem_cs,
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_add,
    output logic [N_DATA_BITS-1:0] mem_wdat,
    input  logic [N_DATA_BITS-1:0] mem_rdat
);

    logic                   sw_win;
    logic                   starve_hit;
    logic                   rd_push;
    logic [RD_LATENCY-1:0]  pipe_vld_r;
    logic [RD_LATENCY-1:0]  pipe_own_r;
    logic                   tail_vld;
    logic                   tail_own;
    logic                   sw_tail;
    logic [N_DATA_BITS-1:0] sw_hold_r;

    // Arbitration: hw has default priority; yield or starvation lets sw through.
    assign sw_win   = sw_cs && (!hw_cs || sw_yield || starve_hit);
    assign sw_grant = sw_win;
    assign hw_gnt   = hw_cs && !sw_win;

    always_comb begin
        mem_cs   = 1'b0;
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        mem_add  = hw_add;
        mem_wdat = hw_wdat;
        if (sw_win) begin
            mem_cs   = 1'b1;
            mem_ce   = sw_ce;
            mem_we   = sw_we;
            mem_add  = sw_add;
            mem_wdat = sw_wdat;
        end else begin
            mem_cs = hw_cs;
            mem_we = hw_cs && hw_we;
        end
    end

`ifdef NX_IA_MEM_ARB_STARVE_EN
    logic [N_STARVE_BITS-1:0] starve_r;

    assign starve_hit = (starve_r == '1);

    // Counts consecutive contested cycles lost by sw; saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_r <= '0;
        end else if (sw_cs && hw_cs && !sw_win) begin
            if (!starve_hit) begin
                starve_r <= starve_r + 1'b1;
            end
        end else begin
            starve_r <= '0;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Any granted non-write (read or compare) returns data RD_LATENCY cycles later.
    assign rd_push = sw_win ? !sw_we : (hw_gnt && !hw_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= '0;
            pipe_own_r <= '0;
        end else begin
            pipe_vld_r[0] <= rd_push;
            pipe_own_r[0] <= sw_win;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_own_r[i] <= pipe_own_r[i-1];
            end
        end
    end

    assign tail_vld = pipe_vld_r[RD_LATENCY-1];
    assign tail_own = pipe_own_r[RD_LATENCY-1];
    assign sw_tail  = tail_vld && tail_own;

    assign hw_rvld = tail_vld && !tail_own;
    assign hw_rdat = mem_rdat;

    // The controller sees stable data between its own reads; hw returns never
    // touch the hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_hold_r <= '0;
        end else if (sw_tail) begin
            sw_hold_r <= mem_rdat;
        end
    end

    assign sw_rdat = sw_tail ? mem_rdat : sw_hold_r;

endmodule
